// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - byte-stream instruction memory loader with core reset control
module imem_loader #(
    parameter int          DEPTH     = 256,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  in_byte,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        we,
    output logic [31:0] waddr,
    output logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        cpu_rst
);

    localparam int IW = $clog2(DEPTH) + 1;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        DATA,
        WRITE,
        DONE,
        ERR
    } state_t;

    state_t        state;
    logic [1:0]    byte_cnt;
    logic [IW-1:0] idx;
    logic [31:0]   shreg;
    logic [31:0]   word_cnt;

    logic          accept;
    logic [31:0]   next_word;
    logic [IW-1:0] idx_next;

    // Bytes arrive least-significant first, so each new byte enters at the top
    assign accept    = in_valid & in_ready;
    assign next_word = {in_byte, shreg[31:8]};
    assign idx_next  = idx + IW'(1);

    // Load sequencer: header word count, then data words, one write pulse each
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            byte_cnt <= 2'd0;
            idx      <= '0;
            shreg    <= 32'd0;
            word_cnt <= 32'd0;
            in_ready <= 1'b0;
            we       <= 1'b0;
            waddr    <= 32'd0;
            wdata    <= 32'd0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            cpu_rst  <= 1'b0;
        end else begin
            we <= 1'b0;
            case (state)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        state    <= HDR;
                        byte_cnt <= 2'd0;
                        idx      <= '0;
                        in_ready <= 1'b1;
                        busy     <= 1'b1;
                        done     <= 1'b0;
                        err      <= 1'b0;
                        cpu_rst  <= 1'b0;
                    end
                end
                HDR: begin
                    if (accept) begin
                        shreg    <= next_word;
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            word_cnt <= next_word;
                            if (next_word == 32'd0) begin
                                state    <= DONE;
                                in_ready <= 1'b0;
                                busy     <= 1'b0;
                                done     <= 1'b1;
                                cpu_rst  <= 1'b1;
                            end else if (next_word > 32'(DEPTH)) begin
                                state    <= ERR;
                                in_ready <= 1'b0;
                                busy     <= 1'b0;
                                err      <= 1'b1;
                            end else begin
                                state <= DATA;
                            end
                        end
                    end
                end
                DATA: begin
                    if (accept) begin
                        shreg    <= next_word;
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            state    <= WRITE;
                            in_ready <= 1'b0;
                            we       <= 1'b1;
                            wdata    <= next_word;
                            waddr    <= BASE_ADDR + (32'(idx) << 2);
                        end
                    end
                end
                WRITE: begin
                    idx <= idx_next;
                    if (32'(idx_next) == word_cnt) begin
                        state   <= DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        cpu_rst <= 1'b1;
                    end else begin
                        state    <= DATA;
                        in_ready <= 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule
